// File: rtl/lii_stream_gearbox.sv
// LII stream gearbox: repacks IW-bit beats LSB-first into OW-bit words.
// Optional counters enabled by defining LII_GEARBOX_STATS_EN.
module lii_stream_gearbox #(
   parameter int IW = 128,
   parameter int OW = 48,
   localparam int CW = $clog2(IW + OW + 1)
) (
   input  logic          aclk,
   input  logic          arst,
   input  logic [IW-1:0] s_tdata,
   input  logic          s_tvalid,
   output logic          s_tready,
   input  logic          s_tlast,
   input  logic [7:0]    s_src,
   input  logic [7:0]    s_dst,
   output logic [OW-1:0] m_tdata,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic          m_tlast,
   output logic [7:0]    m_src,
   output logic [7:0]    m_dst
`ifdef LII_GEARBOX_STATS_EN
   ,
   output logic [31:0]   stat_in_beats,
   output logic [31:0]   stat_out_words,
   output logic [31:0]   stat_pkts
`endif
);

   localparam int BW = IW + OW;
   localparam logic [CW-1:0] OWC = CW'(OW);
   localparam logic [CW-1:0] IWC = CW'(IW);

   logic [BW-1:0] data_buf;
   logic [BW-1:0] nxt_buf;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nxt_cnt;
   logic [CW-1:0] rem;
   logic          flush;
   logic          first;
   logic          push;
   logic          pop;

   // Handshakes and the output word, all from registered state.
   always_comb begin
      s_tready = !arst && (cnt <= OWC) && !flush;
      m_tvalid = (cnt >= OWC) || (flush && (cnt != '0));
      m_tlast  = flush && (cnt <= OWC);
      for (int i = 0; i < OW; i++) begin
         m_tdata[i] = data_buf[i] && (CW'(i) < cnt);
      end
      push = s_tvalid && s_tready;
      pop  = m_tvalid && m_tready;
   end

   // Shift out a popped word and append a pushed beat above the remainder.
   always_comb begin
      rem = cnt;
      if (pop) begin
         rem = (cnt >= OWC) ? (cnt - OWC) : '0;
      end
      nxt_buf = pop ? (data_buf >> OW) : data_buf;
      if (push) begin
         nxt_buf = nxt_buf | (BW'(s_tdata) << rem);
      end
      nxt_cnt = push ? (rem + IWC) : rem;
   end

   // Buffer, fill count, packet framing and tag registers.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         data_buf <= '0;
         cnt      <= '0;
         flush    <= 1'b0;
         first    <= 1'b1;
         m_src    <= '0;
         m_dst    <= '0;
      end else begin
         data_buf <= nxt_buf;
         cnt      <= nxt_cnt;
         if (push) begin
            first <= s_tlast;
         end
         if (push && first) begin
            m_src <= s_src;
            m_dst <= s_dst;
         end
         if (push && s_tlast) begin
            flush <= 1'b1;
         end else if (pop && m_tlast) begin
            flush <= 1'b0;
         end
      end
   end

`ifdef LII_GEARBOX_STATS_EN
   // Saturating traffic counters.
   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         stat_in_beats  <= '0;
         stat_out_words <= '0;
         stat_pkts      <= '0;
      end else begin
         if (push && (stat_in_beats != '1)) begin
            stat_in_beats <= stat_in_beats + 32'd1;
         end
         if (pop && (stat_out_words != '1)) begin
            stat_out_words <= stat_out_words + 32'd1;
         end
         if (pop && m_tlast && (stat_pkts != '1)) begin
            stat_pkts <= stat_pkts + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_lii_stream_gearbox.sv
// Self-checking bench for lii_stream_gearbox (128->48 and 32->48).
// Reference model works on a plain bit queue per packet.
module tb_lii_stream_gearbox;

   localparam int IW = 128;
   localparam int OW = 48;
   localparam int IW1 = 32;

   logic aclk = 1'b0;
   logic arst;
   always #5 aclk = ~aclk;

   logic [IW-1:0] s_tdata;
   logic          s_tvalid, s_tready, s_tlast;
   logic [7:0]    s_src, s_dst;
   logic [OW-1:0] m_tdata;
   logic          m_tvalid, m_tready, m_tlast;
   logic [7:0]    m_src, m_dst;

   logic [IW1-1:0] s1_tdata;
   logic           s1_tvalid, s1_tready, s1_tlast;
   logic [OW-1:0]  m1_tdata;
   logic           m1_tvalid, m1_tready, m1_tlast;
   logic [7:0]     m1_src, m1_dst;

`ifdef LII_GEARBOX_STATS_EN
   logic [31:0] st0_in, st0_out, st0_pk;
   logic [31:0] st1_in, st1_out, st1_pk;
`endif

   lii_stream_gearbox #(.IW(IW), .OW(OW)) dut0 (
      .aclk(aclk), .arst(arst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tlast(s_tlast), .s_src(s_src), .s_dst(s_dst),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_src(m_src), .m_dst(m_dst)
`ifdef LII_GEARBOX_STATS_EN
      , .stat_in_beats(st0_in), .stat_out_words(st0_out),
      .stat_pkts(st0_pk)
`endif
   );

   lii_stream_gearbox #(.IW(IW1), .OW(OW)) dut1 (
      .aclk(aclk), .arst(arst),
      .s_tdata(s1_tdata), .s_tvalid(s1_tvalid), .s_tready(s1_tready),
      .s_tlast(s1_tlast), .s_src(8'd5), .s_dst(8'd6),
      .m_tdata(m1_tdata), .m_tvalid(m1_tvalid), .m_tready(m1_tready),
      .m_tlast(m1_tlast), .m_src(m1_src), .m_dst(m1_dst)
`ifdef LII_GEARBOX_STATS_EN
      , .stat_in_beats(st1_in), .stat_out_words(st1_out),
      .stat_pkts(st1_pk)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   bit          bitq[$];
   logic [OW-1:0] exp_d[$];
   bit          exp_l[$];
   logic [7:0]  exp_s[$];
   logic [7:0]  exp_t[$];
   logic [7:0]  cur_s, cur_t;
   bit          pkt_first = 1'b1;
   bit          rnd_rdy = 1'b0;
   int          npop = 0;
   logic [OW:0] got_q[$];
   logic [OW:0] g1_q[$];

   task automatic emit(input bit last);
      logic [OW-1:0] w;
      w = '0;
      for (int i = 0; i < OW; i++) begin
         if (bitq.size() != 0) w[i] = bitq.pop_front();
      end
      exp_d.push_back(w);
      exp_l.push_back(last);
      exp_s.push_back(cur_s);
      exp_t.push_back(cur_t);
   endtask

   task automatic model_push(input logic [IW-1:0] d, input bit last,
                             input logic [7:0] s, input logic [7:0] t);
      if (pkt_first) begin
         cur_s = s;
         cur_t = t;
      end
      pkt_first = last;
      for (int i = 0; i < IW; i++) bitq.push_back(d[i]);
      while (bitq.size() > OW || (!last && bitq.size() == OW)) emit(1'b0);
      if (last) emit(1'b1);
   endtask

   task automatic model_clear();
      bitq.delete();
      exp_d.delete();
      exp_l.delete();
      exp_s.delete();
      exp_t.delete();
      pkt_first = 1'b1;
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      if (rnd_rdy) m_tready = ($urandom_range(0, 99) < 30);
   endtask

   task automatic send_beat(input logic [IW-1:0] d, input bit last,
                            input logic [7:0] s, input logic [7:0] t);
      int n;
      s_tdata = d;
      s_tlast = last;
      s_src = s;
      s_dst = t;
      s_tvalid = 1'b1;
      n = 0;
      while (!s_tready && n < 1000) begin
         tick();
         n++;
      end
      if (n >= 1000) chk("s_tready_timeout", 0, 1);
      model_push(d, last, s, t);
      tick();
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_d.size() != 0 || m_tvalid) && n < 3000) begin
         tick();
         n++;
      end
      chk("drain", {exp_d.size() == 0, m_tvalid}, 2'b10);
   endtask

   task automatic send1(input logic [IW1-1:0] d, input bit last);
      int n;
      s1_tdata = d;
      s1_tlast = last;
      s1_tvalid = 1'b1;
      n = 0;
      while (!s1_tready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("s1_tready_timeout", 0, 1);
      tick();
      s1_tvalid = 1'b0;
      s1_tlast = 1'b0;
   endtask

   // Scoreboard and stall-stability monitor for the 128->48 instance.
   bit          stall_prev = 1'b0;
   logic [64:0] held;
   always @(negedge aclk) begin
      if (!arst) begin
         if (stall_prev) begin
            chk("hold", {m_tlast, m_src, m_dst, m_tdata}, held);
         end
         if (m_tvalid && m_tready) begin
            if (exp_d.size() == 0) begin
               chk("extra_word", {1'b1, m_tdata}, 0);
            end else begin
               chk("word", {m_tlast, m_src, m_dst, m_tdata},
                   {exp_l[0], exp_s[0], exp_t[0], exp_d[0]});
               void'(exp_d.pop_front());
               void'(exp_l.pop_front());
               void'(exp_s.pop_front());
               void'(exp_t.pop_front());
            end
            got_q.push_back({m_tlast, m_tdata});
            npop++;
         end
         stall_prev = m_tvalid && !m_tready;
         held = {m_tlast, m_src, m_dst, m_tdata};
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Collector for the 32->48 instance.
   always @(negedge aclk) begin
      if (!arst && m1_tvalid && m1_tready) g1_q.push_back({m1_tlast, m1_tdata});
   end

   initial begin
      logic [IW-1:0]  d;
      logic [IW1-1:0] b[3];
      int nb;

      arst = 1'b1;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      s_src = '0; s_dst = '0; m_tready = 1'b1;
      s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0; m1_tready = 1'b1;
      #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_outputs", {m_tvalid, m_tlast, m_src, m_dst, m_tdata}, 0);
      tick();
      tick();
      arst = 1'b0;
      #1;
      chk("post_rst_s_tready", s_tready, 1);

      // Byte-ramp packet: 3 beats -> 8 words
      got_q.delete();
      npop = 0;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 16; j++) d[j*8 +: 8] = 8'(k * 16 + j);
         send_beat(d, k == 2, 8'd1, 8'd2);
      end
      drain();
      chk("ramp_words", npop, 8);
      chk("ramp_last_flag", {got_q[6][OW], got_q[7][OW]}, 2'b01);

      // All-ones single beat -> 3 words, last one zero-padded
      got_q.delete();
      send_beat('1, 1'b1, 8'd1, 8'd1);
      drain();
      chk("ones_count", got_q.size(), 3);
      chk("ones_w0", got_q[0], {1'b0, 48'hFFFFFFFFFFFF});
      chk("ones_w2", got_q[2], {1'b1, 48'h0000FFFFFFFF});

      // Back-to-back packets with distinct tags
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 8'd3, 8'd7);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, 8'd3, 8'd7);
      chk("busy_during_flush", s_tready, 0);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, 8'd4, 8'd9);
      drain();

      // 20 random packets under 30% output-ready duty
      rnd_rdy = 1'b1;
      for (int p = 0; p < 20; p++) begin
         nb = $urandom_range(1, 4);
         for (int k = 0; k < nb; k++) begin
            send_beat({$urandom, $urandom, $urandom, $urandom}, k == nb - 1,
                      8'($urandom), 8'($urandom));
         end
      end
      drain();
      rnd_rdy = 1'b0;

      // Reset in the middle of a packet
      m_tready = 1'b0;
      send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 8'd1, 8'd2);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      arst = 1'b1;
      #1;
      chk("midrst_tvalid", m_tvalid, 0);
      chk("midrst_tready", s_tready, 0);
      model_clear();
      tick();
      arst = 1'b0;
      #1;
      chk("rel_s_tready", s_tready, 1);
      chk("rel_m_tvalid", m_tvalid, 0);
      m_tready = 1'b1;
      got_q.delete();
      d = {$urandom, $urandom, $urandom, $urandom};
      send_beat(d, 1'b1, 8'd8, 8'd8);
      drain();
      chk("fresh_first", got_q[0], {1'b0, d[OW-1:0]});

      // Narrow input: 3 x 32-bit beats -> 2 words
      g1_q.delete();
      for (int k = 0; k < 3; k++) b[k] = $urandom;
      for (int k = 0; k < 3; k++) send1(b[k], k == 2);
      for (int k = 0; k < 10; k++) tick();
      chk("narrow_count", g1_q.size(), 2);
      chk("narrow_w0", g1_q[0], {1'b0, b[1][15:0], b[0]});
      chk("narrow_w1", g1_q[1], {1'b1, b[2], b[1][31:16]});
      chk("narrow_tags", {m1_src, m1_dst}, {8'd5, 8'd6});
`ifdef LII_GEARBOX_STATS_EN
      chk("stat_in", st1_in, 3);
      chk("stat_out", st1_out, 2);
      chk("stat_pkts", st1_pk, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
